// File: rtl/sme_job_sequencer.sv
// Front-end job sequencer for the string matching engine: buffers one string and
// a queue of patterns, replays them over the SME char protocol, returns tagged results.
module sme_job_sequencer #(
  parameter int PQ_DEPTH = 4,
  parameter int TIMEOUT  = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       str_we,
  input  logic [7:0] str_char,
  input  logic       str_last,
  output logic       str_ready,
  input  logic       pat_we,
  input  logic [7:0] pat_char,
  input  logic       pat_last,
  output logic       pat_ready,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic [3:0] res_tag,
  output logic       busy
);
  localparam int PW = $clog2(PQ_DEPTH);
  localparam int CW = ($clog2(TIMEOUT) > 6) ? $clog2(TIMEOUT) : 6;

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, GAP, WAIT, RESULT} state_t;
  state_t state, state_next;

  logic [7:0]    str_mem [32];
  logic [5:0]    str_len;
  logic          str_done, str_dirty;
  logic [63:0]   stage_data, commit_data;
  logic [3:0]    stage_len, commit_len;
  logic [63:0]   pq_data [PQ_DEPTH];
  logic [3:0]    pq_len  [PQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [CW-1:0] cnt;

  logic str_acc, str_wr_en, pq_full, push, pop, dispatch, stage_put;
  logic str_end, pat_end, to_end;
  logic [4:0] str_wr_idx;

  assign str_acc    = str_we && (state == IDLE);
  assign str_wr_idx = str_done ? 5'd0 : str_len[4:0];
  assign str_wr_en  = str_acc && (str_done || (str_len != 6'd32));
  assign pq_full    = (count == (PW+1)'(PQ_DEPTH));
  assign push       = pat_we && pat_last && !pq_full;
  assign pop        = (state == RESULT) && res_ready;
  assign dispatch   = (state == IDLE) && (count != '0) && (str_len != '0) && str_done;
  assign stage_put  = (stage_len != 4'd8);
  assign str_end    = (cnt == CW'(str_len) - CW'(1));
  assign pat_end    = (cnt == CW'(pq_len[rd_ptr]) - CW'(1));
  assign to_end     = (cnt == CW'(TIMEOUT - 1));

  // The committing char joins the staged pattern unless it is already 8 long.
  always_comb begin
    commit_data = stage_data;
    commit_len  = stage_len;
    if (stage_put) begin
      commit_data[{stage_len[2:0], 3'b000} +: 8] = pat_char;
      commit_len = stage_len + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (dispatch) state_next = str_dirty ? SEND_STR : SEND_PAT;
      SEND_STR: if (str_end) state_next = SEND_PAT;
      SEND_PAT: if (pat_end) state_next = GAP;
      GAP:      state_next = WAIT;
      WAIT:     if (sme_valid || to_end) state_next = RESULT;
      RESULT:   if (res_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    str_ready     = (state == IDLE);
    busy          = (state != IDLE);
    pat_ready     = !pq_full;
    res_valid     = (state == RESULT);
    sme_isstring  = (state == SEND_STR);
    sme_ispattern = (state == SEND_PAT);
    sme_chardata  = '0;
    if (state == SEND_STR) sme_chardata = str_mem[cnt[4:0]];
    else if (state == SEND_PAT) sme_chardata = pq_data[rd_ptr][{cnt[2:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (state inside {SEND_STR, SEND_PAT, WAIT}) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (str_wr_en) str_mem[str_wr_idx] <= str_char;
    if (push) begin
      pq_data[wr_ptr] <= commit_data;
      pq_len[wr_ptr]  <= commit_len;
    end
  end

  // A write following a completed string restarts the buffer at length 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_len   <= '0;
      str_done  <= 1'b0;
      str_dirty <= 1'b0;
    end else if (str_acc) begin
      if (str_done)              str_len <= 6'd1;
      else if (str_len != 6'd32) str_len <= str_len + 6'd1;
      str_done <= str_last;
      if (str_last) str_dirty <= 1'b1;
    end else if (state == SEND_STR) begin
      str_dirty <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_data <= '0;
      stage_len  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (pat_we) begin
        if (pat_last) begin
          if (!pq_full) begin
            stage_data <= '0;
            stage_len  <= '0;
          end
        end else if (stage_put) begin
          stage_data <= commit_data;
          stage_len  <= commit_len;
        end
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  // sme_valid takes priority over the timeout when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_tag     <= '0;
      res_match   <= 1'b0;
      res_index   <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (dispatch) res_tag <= res_tag + 4'd1;
      if (state == WAIT) begin
        if (sme_valid) begin
          res_match   <= sme_match;
          res_index   <= sme_match_index;
          res_timeout <= 1'b0;
        end else if (to_end) begin
          res_match   <= 1'b0;
          res_index   <= '0;
          res_timeout <= 1'b1;
        end
      end
    end
  end
endmodule
